// File: rtl/vga_sync_receiver.sv
// VGA sync sink: synchronizes hsync/vsync, rebuilds pixel/line counters,
// checks line and frame geometry against the configured mode, and reports
// lock plus display-enable and active x/y.
module vga_sync_receiver #(
  parameter int CLK_PER_PIX = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_ACT_START = 144,
  parameter int H_ACT       = 640,
  parameter int V_TOTAL     = 521,
  parameter int V_ACT_START = 31,
  parameter int V_ACT       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       de,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       err
);

  localparam logic [12:0] LINE_LAST = 13'(H_TOTAL*CLK_PER_PIX-1);
  localparam logic [12:0] LCLK_MAX  = 13'h1FFF;
  localparam logic [1:0]  SUB_LAST  = 2'(CLK_PER_PIX-1);
  localparam logic [10:0] HPOS_MAX  = 11'h7FF;
  localparam logic [10:0] H_A0      = 11'(H_ACT_START);
  localparam logic [10:0] H_A1      = 11'(H_ACT_START+H_ACT);
  localparam logic [9:0]  V_A0      = 10'(V_ACT_START);
  localparam logic [9:0]  V_A1      = 10'(V_ACT_START+V_ACT);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL-1);
  localparam logic [9:0]  V_FULL    = 10'(V_TOTAL);
  localparam logic [9:0]  VPOS_MAX  = 10'h3FF;
  localparam logic [8:0]  LOCK_N    = 9'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_e;

  // [0],[1] synchronizer stages, [2] delay flop for edge detect
  logic [2:0]  hs_q, vs_q;
  logic [1:0]  sub_q, sub_d;
  logic [10:0] hpos_q, hpos_d;
  logic [12:0] lclk_q, lclk_d;
  logic [9:0]  vpos_q, vpos_d;
  logic        v_pend_q, v_pend_d;
  logic        frame_bad_q, frame_bad_d;
  state_e      state_q, state_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic        err_q, err_d, locked_q, locked_d;
  logic        de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;

  logic h_fall, v_fall, line_bad, fb, frame_good, timeout, h_in, v_in;

  assign h_fall   = hs_q[2] & ~hs_q[1];
  assign v_fall   = vs_q[2] & ~vs_q[1];
  assign line_bad = h_fall && (lclk_q != LINE_LAST);
  assign timeout  = (lclk_q == LCLK_MAX);
  // A vsync fall right after an hsync fall belongs to that line start; a late
  // one waits for the next hsync fall so the boundary always sits on a line.
  assign fb = (h_fall && (v_fall || v_pend_q)) ||
              (!h_fall && v_fall && (lclk_q < 13'd8));
  // In the immediate case the preceding hsync fall has already counted the
  // new line, so the full line count shows up as V_TOTAL instead of V_TOTAL-1.
  assign frame_good = (h_fall ? (vpos_q == V_LAST) : (vpos_q == V_FULL)) &&
                      !frame_bad_q && !line_bad;

  // Input synchronizers, idle-high after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q <= 3'b111;
      vs_q <= 3'b111;
    end else begin
      hs_q <= {hs_q[1:0], hsync_in};
      vs_q <= {vs_q[1:0], vsync_in};
    end
  end

  // Next-state for horizontal/vertical counters and frame bookkeeping
  always_comb begin
    sub_d       = sub_q;
    hpos_d      = hpos_q;
    lclk_d      = lclk_q;
    vpos_d      = vpos_q;
    v_pend_d    = v_pend_q;
    frame_bad_d = frame_bad_q;
    if (h_fall) begin
      sub_d  = '0;
      hpos_d = '0;
      lclk_d = '0;
    end else begin
      if (lclk_q != LCLK_MAX) lclk_d = lclk_q + 13'd1;
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        if (hpos_q != HPOS_MAX) hpos_d = hpos_q + 11'd1;
      end else begin
        sub_d = sub_q + 2'd1;
      end
    end
    if (fb) begin
      vpos_d   = '0;
      v_pend_d = 1'b0;
    end else begin
      if (h_fall && vpos_q != VPOS_MAX) vpos_d = vpos_q + 10'd1;
      if (v_fall && !h_fall)            v_pend_d = 1'b1;
    end
    if (fb)            frame_bad_d = 1'b0;
    else if (line_bad) frame_bad_d = 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_q       <= '0;
      hpos_q      <= '0;
      lclk_q      <= '0;
      vpos_q      <= '0;
      v_pend_q    <= 1'b0;
      frame_bad_q <= 1'b0;
    end else begin
      sub_q       <= sub_d;
      hpos_q      <= hpos_d;
      lclk_q      <= lclk_d;
      vpos_q      <= vpos_d;
      v_pend_q    <= v_pend_d;
      frame_bad_q <= frame_bad_d;
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SEARCH;
      good_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  // Lock FSM next-state
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      SEARCH: if (fb) begin
        state_d    = VERIFY;
        good_cnt_d = '0;
      end
      VERIFY: begin
        if (timeout) begin
          state_d = SEARCH;
        end else if (fb) begin
          if (!frame_good)                               good_cnt_d = '0;
          else if ({1'b0, good_cnt_q} + 9'd1 >= LOCK_N)  state_d = LOCKED;
          else                                           good_cnt_d = good_cnt_q + 8'd1;
        end
      end
      LOCKED: if (line_bad || (fb && !frame_good) || timeout) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  // Lock FSM outputs: err marks the LOCKED exit, locked tracks the new state
  always_comb begin
    err_d    = (state_q == LOCKED) && (state_d != LOCKED);
    locked_d = (state_d == LOCKED);
  end

  // Active-window decode
  always_comb begin
    h_in    = (hpos_q >= H_A0) && (hpos_q < H_A1);
    v_in    = (vpos_q >= V_A0) && (vpos_q < V_A1);
    de_d    = (state_q == LOCKED) && h_in && v_in;
    pix_x_d = de_d ? 10'(hpos_q - H_A0) : '0;
    pix_y_d = de_d ? (vpos_q - V_A0) : '0;
    ls_d    = de_d && (hpos_q == H_A0) && (sub_q == 2'd0);
    fs_d    = ls_d && (vpos_q == V_A0);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      de_q     <= 1'b0;
      pix_x_q  <= '0;
      pix_y_q  <= '0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      err_q    <= err_d;
      locked_q <= locked_d;
      de_q     <= de_d;
      pix_x_q  <= pix_x_d;
      pix_y_q  <= pix_y_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a reduced mode (20x12 pixels, 4 clk/pixel).
// A frame generator walks a table of frame geometries; expected outputs are
// queued per driven pixel and checked when due, 4 ticks later.
module tb_vga_sync_receiver;
  localparam int CPP = 4, HT = 20, HAS = 6, HA = 10, VT = 12, VAS = 3, VA = 6, LF = 2;
  localparam int HSW = 2, VSW = 2;

  logic       clk = 1'b0, rst_n = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [9:0] pix_x, pix_y;
  logic       de, ls, fs, locked, err;

  vga_sync_receiver #(
    .CLK_PER_PIX(CPP), .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT(HA),
    .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT(VA), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst_n), .hsync_in(hs), .vsync_in(vs),
    .pix_x(pix_x), .pix_y(pix_y), .de(de), .line_start(ls),
    .frame_start(fs), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nlines; int short_line; int vdelay; bit chk; bit exp_lk; int exp_err; int rst_line;
  } vec_t;
  typedef struct { int due; bit de; int x; int y; bit ls; bit fs; } exp_t;

  exp_t sbq[$];
  vec_t vecs[24];
  int   n_tests = 0, n_fail = 0, cyc = 0, err_cnt = 0;
  bit   prev_lk = 1'b0, prev_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  // One clock: advance, then check due scoreboard entries and err pulses
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      chk("de", de, e.de);
      chk("pix_x", pix_x, e.x);
      chk("pix_y", pix_y, e.y);
      chk("line_start", ls, e.ls);
      chk("frame_start", fs, e.fs);
    end
    if (err) begin
      err_cnt++;
      chk("err_pulse_shape", {prev_err, prev_lk, locked}, 3'b010);
    end
    prev_err = err;
    prev_lk  = locked;
  endtask

  // Drive one frame; vsync falls vdelay clocks after the line-0 hsync fall
  task automatic gen_frame(input vec_t v);
    err_cnt = 0;
    for (int ln = 0; ln < v.nlines; ln++) begin
      int npix;
      npix = (ln == v.short_line) ? HT - 1 : HT;
      for (int hp = 0; hp < npix; hp++) begin
        for (int s = 0; s < CPP; s++) begin
          int t;
          exp_t e;
          t = hp * CPP + s;
          tick();
          if (!rst_n && hp == 0 && s == 0) rst_n = 1'b1;
          hs = !(hp < HSW);
          vs = !((ln == 0 && t >= v.vdelay) || (ln > 0 && ln < VSW));
          if (v.chk) begin
            e.due = cyc + 4;
            e.de  = (hp >= HAS) && (hp < HAS + HA) && (ln >= VAS) && (ln < VAS + VA);
            e.x   = e.de ? hp - HAS : 0;
            e.y   = e.de ? ln - VAS : 0;
            e.ls  = e.de && (hp == HAS) && (s == 0);
            e.fs  = e.ls && (ln == VAS);
            sbq.push_back(e);
          end
          if (ln == 1 && hp == 0 && s == 0) chk("locked_at_line1", locked, v.exp_lk);
          if (ln == v.rst_line && hp == HAS + 3 && s == 1) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_de", de, 0);
            chk("rst_pix_x", pix_x, 0);
            chk("rst_pix_y", pix_y, 0);
            chk("rst_locked", locked, 0);
            chk("rst_err", err, 0);
          end
        end
      end
    end
  endtask

  initial begin
    int k;
    bit found;
    //            lines short vdly chk lk err rst
    vecs[0]  = '{12, -1, 0, 0, 0, 0, -1};  // first boundary: SEARCH->VERIFY
    vecs[1]  = '{12, -1, 0, 0, 0, 0, -1};
    vecs[2]  = '{12, -1, 0, 1, 1, 0, -1};  // lock at 3rd vsync fall
    vecs[3]  = '{12, -1, 0, 1, 1, 0, -1};
    vecs[4]  = '{12,  5, 0, 0, 1, 1, -1};  // 19-pixel line while locked
    vecs[5]  = '{12, -1, 0, 0, 0, 0, -1};
    vecs[6]  = '{12, -1, 0, 0, 0, 0, -1};
    vecs[7]  = '{12, -1, 0, 1, 1, 0, -1};  // relock after 2 good frames
    vecs[8]  = '{11, -1, 0, 1, 1, 0, -1};  // short frame, caught at next boundary
    vecs[9]  = '{12, -1, 0, 0, 0, 1, -1};
    vecs[10] = '{12, -1, 0, 0, 0, 0, -1};
    vecs[11] = '{12, -1, 0, 0, 0, 0, -1};
    vecs[12] = '{12, -1, 0, 1, 1, 0, -1};
    vecs[13] = '{11, -1, 0, 1, 1, 0, -1};  // short frame again ...
    vecs[14] = '{12, -1, 1, 0, 0, 1, -1};  // ... ended by vsync 1 clk late
    vecs[15] = '{12, -1, 0, 0, 0, 0, -1};
    vecs[16] = '{12, -1, 0, 0, 0, 0, -1};
    vecs[17] = '{12, -1, 0, 1, 1, 0, -1};
    vecs[18] = '{12, -1, 1, 1, 1, 0, -1};  // late vsync on a good frame keeps lock
    vecs[19] = '{12, -1, 0, 1, 1, 0, -1};
    vecs[20] = '{12, -1, 0, 0, 1, 0,  4};  // reset mid active line 4
    vecs[21] = '{12, -1, 0, 0, 0, 0, -1};
    vecs[22] = '{12, -1, 0, 0, 0, 0, -1};
    vecs[23] = '{12, -1, 0, 1, 1, 0, -1};  // lock back after 3 vsync falls

    repeat (3) tick();
    chk("reset_pix_x", pix_x, 0);
    chk("reset_pix_y", pix_y, 0);
    chk("reset_de", de, 0);
    chk("reset_line_start", ls, 0);
    chk("reset_frame_start", fs, 0);
    chk("reset_locked", locked, 0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 24; i++) begin
      gen_frame(vecs[i]);
      chk($sformatf("err_count_row%0d", i), err_cnt, vecs[i].exp_err);
    end

    // hsync stops while locked: lclk saturates and lock drops with err
    err_cnt = 0;
    tick();
    hs = 1'b0;
    k  = cyc;
    for (int i = 1; i < HSW * CPP; i++) tick();
    hs = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 9000 && !found; i++) begin
      tick();
      if (err) found = 1'b1;
    end
    chk("timeout_err_seen", found, 1);
    chk("timeout_delay", cyc - k, 8195);
    chk("timeout_locked", locked, 0);
    chk("timeout_err_count", err_cnt, 1);
    repeat (2) tick();
    chk("timeout_de", de, 0);
    chk("timeout_err_cleared", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
